seq_detect_fsm: RTL
===================

# seq_detect_fsm

Parametrised serial pattern-detector FSM. It samples a 1-bit input stream under an enable strobe and compares a sliding window against a compile-time pattern. On a match it raises a Moore output for a programmable number of cycles and counts matches. It sits beside the control FSMs in the FPGA fabric, generalising the fixed four-state x1/outp machine to any pattern width, overlap mode and output hold length.

## Interface
- PAT_W, 4, pattern width in bits (legal 2..16)
- PATTERN, 4'b1011, pattern to detect, MSB = oldest bit
- HOLD, 2, cycles outp stays high per match (legal 1..255)
- CNT_W, 8, match counter width (legal 2..16)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- en  in  1  sample strobe; x1 is consumed only on cycles with en=1
- x1  in  1  serial data bit
- overlap  in  1  1 = overlapping matches allowed, 0 = window cleared after each match
- clr_cnt  in  1  synchronous clear of match_cnt
- outp  out  1  Moore output, high while state = S_HIT
- state  out  2  current state encoding, for debug
- match_cnt  out  CNT_W  saturating match count

## Operation
- Window: shreg[PAT_W-1:0]; on en=1, shreg <= {shreg[PAT_W-2:0], x1}; fill <= min(fill+1, PAT_W).
- Match event, combinational from current-cycle inputs: en=1 AND {shreg[PAT_W-2:0], x1} == PATTERN AND fill >= PAT_W-1.
- States: S_FILL=2'b00 (fill < PAT_W), S_SCAN=2'b01 (window full, no output), S_HIT=2'b10 (outp=1). 2'b11 is illegal and goes to S_FILL on the next edge with outputs low.
- Transitions:
  - Any state with a match event -> S_HIT, hold_cnt <= HOLD-1. A match in S_HIT retriggers by reloading hold_cnt.
  - S_FILL, no match: stays until fill reaches PAT_W, then -> S_SCAN.
  - S_HIT, no match, hold_cnt != 0: stays, hold_cnt decrements.
  - S_HIT, no match, hold_cnt == 0: -> S_SCAN if the next fill == PAT_W, else -> S_FILL.
- Overlap: sampled on the match edge.
  - overlap=1: fill is unchanged, so the next match may share bits with this one.
  - overlap=0: fill <= 0 and the state still goes to S_HIT. The next match needs PAT_W fresh en-qualified bits.
- Counter: match_cnt increments on each match event and saturates at all-ones.
  - clr_cnt has priority: clr_cnt together with a match gives 0.
- en=0: shreg, fill and match detection are frozen. The hold countdown still runs on every clock.

## Timing
- Reset (reset=0): state=S_FILL, outp=0, match_cnt=0, shreg=0, fill=0, hold_cnt=0, all asynchronous. Deassertion is taken synchronously on the next edge.
- Latency: the last pattern bit is sampled at edge N; outp is high from after edge N through edge N+HOLD (exactly HOLD cycles), low after edge N+HOLD.
- match_cnt updates at the same edge N.
- A retrigger at edge M while in S_HIT extends outp through edge M+HOLD with no low gap.
- Reset asserted mid-hold drops outp within the same cycle (asynchronous); no pending match survives.
- state, outp and match_cnt are registered or decoded from registers only. There is no combinational path from x1 or en to any output.

## Test plan
- reset=0 mid-stream while outp=1 and match_cnt=5 -> outp=0, state=2'b00 and match_cnt=0 immediately, before the next edge.
- Defaults, en=1, x1 = 1,0,1,1 on edges 1..4 -> state S_FILL through edge 3, S_HIT after edge 4; outp=1 for edges 5..6 only; match_cnt=1.
- overlap=1, x1 = 1,0,1,1,0,1,1 -> matches at edges 4 and 7, match_cnt=2, outp high on cycles 5-6 and 8-9. The same stream with overlap=0 -> only the edge-4 match, match_cnt=1.
- HOLD=4 build, x1 = 1,0,1,1,0,1,1 with overlap=1 -> retrigger at edge 7; outp continuously high cycles 5..11.
- en toggled 1,0,1,0,1,0,1 with x1 = 1,X,0,X,1,X,1 -> X bits ignored; match on the 4th en-qualified bit, outp rises the cycle after.
- CNT_W=2 build, 5 matches -> match_cnt sticks at 3. clr_cnt=1 on the same edge as a 6th match -> match_cnt=0, and outp still asserts.

Source files
------------

// File: rtl/seq_detect_fsm.sv
// seq_detect_fsm: serial pattern detector over an en-qualified bit stream.
// Ports: clk, reset (async, active-low), en (sample strobe), x1 (data bit),
//        overlap (keep fill on match), clr_cnt (sync counter clear),
//        outp (Moore, high in S_HIT), state (debug), match_cnt (saturating).
module seq_detect_fsm #(
  parameter int unsigned       PAT_W   = 4,
  parameter logic [PAT_W-1:0]  PATTERN = 4'b1011,
  parameter int unsigned       HOLD    = 2,
  parameter int unsigned       CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x1,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             outp,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned         FILL_W      = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0]   FILL_FULL   = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0]   FILL_LAST   = FILL_W'(PAT_W - 1);
  localparam logic [7:0]          HOLD_RELOAD = 8'(HOLD - 1);

  typedef enum logic [1:0] {
    S_FILL = 2'b00,
    S_SCAN = 2'b01,
    S_HIT  = 2'b10,
    S_BAD  = 2'b11
  } state_t;

  state_t              cur;
  state_t              nxt;
  // Oldest window bit is shifted out before it is ever compared, so only
  // PAT_W-1 history bits are stored; the window is completed by x1.
  logic [PAT_W-2:0]    hist;
  logic [PAT_W-2:0]    hist_nxt;
  logic [PAT_W-1:0]    window;
  logic [FILL_W-1:0]   fill;
  logic [FILL_W-1:0]   fill_nxt;
  logic [7:0]          hold_cnt;
  logic [7:0]          hold_nxt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                match;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur       <= S_FILL;
      hist      <= '0;
      fill      <= '0;
      hold_cnt  <= '0;
      match_cnt <= '0;
    end else begin
      cur       <= nxt;
      hist      <= hist_nxt;
      fill      <= fill_nxt;
      hold_cnt  <= hold_nxt;
      match_cnt <= cnt_nxt;
    end
  end

  // Next-state and datapath
  always_comb begin
    window   = {hist, x1};
    match    = en && (window == PATTERN) && (fill >= FILL_LAST);
    hist_nxt = hist;
    fill_nxt = fill;
    hold_nxt = hold_cnt;
    nxt      = cur;
    cnt_nxt  = match_cnt;

    if (en) begin
      hist_nxt = window[PAT_W-2:0];
      if (match && !overlap)
        fill_nxt = '0;
      else if (fill != FILL_FULL)
        fill_nxt = fill + FILL_W'(1);
    end

    if (cur == S_BAD) begin
      nxt      = S_FILL;
      hold_nxt = '0;
    end else if (match) begin
      nxt      = S_HIT;
      hold_nxt = HOLD_RELOAD;
    end else begin
      case (cur)
        S_FILL: if (fill_nxt == FILL_FULL) nxt = S_SCAN;
        S_SCAN: nxt = S_SCAN;
        S_HIT: begin
          if (hold_cnt != 8'd0)
            hold_nxt = hold_cnt - 8'd1;
          else
            nxt = (fill_nxt == FILL_FULL) ? S_SCAN : S_FILL;
        end
        default: nxt = S_FILL;
      endcase
    end

    if (clr_cnt)
      cnt_nxt = '0;
    else if (match && (match_cnt != '1))
      cnt_nxt = match_cnt + CNT_W'(1);
  end

  // Outputs decoded from registers only
  always_comb begin
    outp  = (cur == S_HIT);
    state = cur;
  end

endmodule
